// File: rtl/sd_emmc_axi_pkg.sv
// -----------------------------------------------------------------------------
// sd_emmc_axi_pkg
//   Shared definitions for the SD/eMMC controller AXI write-burst master:
//   - wr_state_t        : burst FSM state encoding (IDLE is all-zero)
//   - AXI_* constants   : AXI4 burst type, beat size and response codes
//   - DEFAULT_BURST_LEN : default number of 32-bit beats per burst (64 bytes)
//   - resp_is_error()   : true for SLVERR / DECERR responses
// -----------------------------------------------------------------------------
package sd_emmc_axi_pkg;

   localparam int DEFAULT_BURST_LEN = 16;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // IDLE must stay at zero: the state register doubles as a debug output
   // that has to read 0 while reset is asserted.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_RESP = 3'd3,
      ST_DONE = 3'd4
   } wr_state_t;

   // Both error responses have bit 1 set; written out in full so the
   // intent reads directly from the response names.
   function automatic logic resp_is_error(input logic [1:0] resp);
      return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
   endfunction

endpackage

// File: rtl/sd_emmc_controller_axi_wr_burst.sv
// -----------------------------------------------------------------------------
// sd_emmc_controller_axi_wr_burst
//   AXI4 write-burst master used by the SD/eMMC DMA path. One request from the
//   DMA produces one fixed-length INCR burst of BURST_LEN 32-bit beats, fed
//   word by word from the data FIFO, followed by collection of the B response.
//
//   Handshake rule for every valid/ready pair on this block: a transfer
//   happens in a cycle where valid and ready are both high at the rising
//   clock edge; valid, once raised by this block, is held until that cycle.
//
// Ports
//   clock, reset          : clock, asynchronous active-high reset
//   write_addr            : burst start address (latched on request in IDLE)
//   addr_write_valid      : DMA requests a burst (only looked at in IDLE)
//   addr_write_ready      : 1-cycle pulse in the AW handshake cycle
//   data_write_valid      : DMA offers fifo_dat
//   fifo_dat              : data word, passed straight through to WDATA
//   next_data_word        : 1-cycle pulse in each W handshake cycle
//   w_last                : burst finished, B response collected (DONE)
//   m_axi_aw*             : AXI write-address channel
//   m_axi_w*              : AXI write-data channel
//   m_axi_b*              : AXI write-response channel
//   wr_err                : sticky error (SLVERR/DECERR or misaligned address)
//   err_clr               : clears wr_err; a simultaneous set wins
//   busy                  : state is not IDLE
//   fsm_state             : current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module sd_emmc_controller_axi_wr_burst
   import sd_emmc_axi_pkg::*;
#(
   parameter int BURST_LEN = DEFAULT_BURST_LEN,
   parameter int ADDR_W    = 32
) (
   input  logic              clock,
   input  logic              reset,

   input  logic [ADDR_W-1:0] write_addr,
   input  logic              addr_write_valid,
   output logic              addr_write_ready,
   input  logic              data_write_valid,
   input  logic [31:0]       fifo_dat,
   output logic              next_data_word,
   output logic              w_last,

   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic [7:0]        m_axi_awlen,
   output logic [2:0]        m_axi_awsize,
   output logic [1:0]        m_axi_awburst,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,

   output logic [31:0]       m_axi_wdata,
   output logic [3:0]        m_axi_wstrb,
   output logic              m_axi_wlast,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,

   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,

   output logic              wr_err,
   input  logic              err_clr,
   output logic              busy,
   output wr_state_t         fsm_state
);

   // A one-beat burst still needs a 1-bit counter.
   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
   localparam logic [7:0]       AW_LEN    = 8'(BURST_LEN - 1);

   wr_state_t        state;
   logic [CNT_W-1:0] beat_cnt;

   logic in_data;
   logic w_hs;
   logic req_accept;
   logic misaligned;
   logic resp_err;
   logic err_set;

   // ---------------------------------------------------------------------------
   // Combinational decode
   // ---------------------------------------------------------------------------
   assign in_data    = (state == ST_DATA);
   assign w_hs       = in_data & data_write_valid & m_axi_wready;
   assign req_accept = (state == ST_IDLE) & addr_write_valid;

   // Bursts must start on a 64-byte boundary; anything else is flagged but
   // still issued at the requested address.
   assign misaligned = req_accept & (write_addr[5:0] != 6'd0);
   assign resp_err   = (state == ST_RESP) & m_axi_bvalid & resp_is_error(m_axi_bresp);
   assign err_set    = misaligned | resp_err;

   // awvalid is always high in ADDR, so awready alone marks the AW handshake.
   assign addr_write_ready = (state == ST_ADDR) & m_axi_awready;

   // The W channel is a pass-through of the FIFO interface while in DATA and
   // quiet everywhere else, so nothing leaks onto the bus during DONE.
   assign m_axi_wvalid   = in_data & data_write_valid;
   assign m_axi_wdata    = in_data ? fifo_dat : 32'd0;
   assign m_axi_wstrb    = in_data ? 4'hF : 4'h0;
   assign m_axi_wlast    = in_data & (beat_cnt == LAST_BEAT);
   assign next_data_word = w_hs;

   assign m_axi_bready = (state == ST_RESP);
   assign w_last       = (state == ST_DONE);
   assign busy         = (state != ST_IDLE);
   assign fsm_state    = state;

   // ---------------------------------------------------------------------------
   // Burst FSM, beat counter and sticky error
   // ---------------------------------------------------------------------------
   // The AW length/size/burst fields are loaded with their fixed values on
   // the first request and never change afterwards; they are registers only
   // so that they read zero while reset is asserted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         beat_cnt      <= '0;
         m_axi_awaddr  <= '0;
         m_axi_awlen   <= 8'd0;
         m_axi_awsize  <= 3'd0;
         m_axi_awburst <= 2'd0;
         m_axi_awvalid <= 1'b0;
         wr_err        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (addr_write_valid) begin
                  m_axi_awaddr  <= write_addr;
                  m_axi_awlen   <= AW_LEN;
                  m_axi_awsize  <= AXI_SIZE_4B;
                  m_axi_awburst <= AXI_BURST_INCR;
                  m_axi_awvalid <= 1'b1;
                  beat_cnt      <= '0;
                  state         <= ST_ADDR;
               end
            end

            ST_ADDR: begin
               if (m_axi_awready) begin
                  m_axi_awvalid <= 1'b0;
                  state         <= ST_DATA;
               end
            end

            ST_DATA: begin
               // A cycle without data_write_valid is a stall: no count change.
               if (w_hs) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
                  if (beat_cnt == LAST_BEAT) begin
                     state <= ST_RESP;
                  end
               end
            end

            ST_RESP: begin
               if (m_axi_bvalid) begin
                  state <= ST_DONE;
               end
            end

            ST_DONE: begin
               // The DMA acknowledges completion by presenting its next word;
               // that word is not consumed here.
               if (data_write_valid) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase

         // Errors never abort the burst; they are only recorded.
         if (err_set) begin
            wr_err <= 1'b1;
         end else if (err_clr) begin
            wr_err <= 1'b0;
         end
      end
   end

endmodule
